// File: rtl/addsub_serial_ctrl.sv
// Bit-serial N-bit adder/subtractor controller: one full-adder step per clock, LSB first.
// Optional build macro ADDSUB_OVF_EN enables the signed overflow flag; otherwise ovf is held at 0.
module addsub_serial_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   acc;
  logic           carry;

  // Full adder built as two half-adder stages on the current LSBs
  logic ha1_s, ha1_c, ha2_c;
  logic sum_bit, carry_nxt;

  assign ha1_s     = a_sr[0] ^ b_sr[0];
  assign ha1_c     = a_sr[0] & b_sr[0];
  assign sum_bit   = ha1_s ^ carry;
  assign ha2_c     = ha1_s & carry;
  assign carry_nxt = ha1_c | ha2_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is A + ~B + 1: invert B and seed the carry with mode
            a_sr  <= a;
            b_sr  <= b ^ {N{mode}};
            carry <= mode;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          acc   <= {sum_bit, acc[N-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            result <= {sum_bit, acc[N-1:1]};
            cout   <= carry_nxt;
`ifdef ADDSUB_OVF_EN
            // Carry into the MSB is the carry register during the final step
            ovf    <= carry ^ carry_nxt;
`else
            ovf    <= 1'b0;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Scoreboard bench for addsub_serial_ctrl (N=4): directed vectors, queue-based done monitor.
module tb_addsub_serial_ctrl;

  localparam int unsigned N = 4;
`ifdef ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;

  addsub_serial_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] r;
    logic         c;
    logic         o;
    int           at;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("result", int'(result), int'(e.r));
        chk("cout", int'(cout), int'(e.c));
        chk("ovf", int'(ovf), int'(e.o));
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Issue one operation, push its expectation, and check busy for N cycles
  task automatic do_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vm,
                       input logic [N-1:0] er, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; mode = vm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.r = er; e.c = ec; e.o = eo & OVF_ON; e.at = cyc + N;
    sbq.push_back(e);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("busy_during_shift", int'(busy), 1);
    end
    drain();
  endtask

  initial begin
    exp_t e;
    int   k;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic
    do_op(4'd5,  4'd3, 1'b0, 4'b1000, 1'b0, 1'b1);
    do_op(4'd7,  4'd2, 1'b1, 4'b0101, 1'b1, 1'b0);
    do_op(4'd2,  4'd7, 1'b1, 4'b1011, 1'b0, 1'b0);
    do_op(4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("hold_result_idle", int'(result), 0);
    chk("hold_cout_idle", int'(cout), 1);

    // start and operand change during SHIFT are ignored: 9+4
    @(negedge clk);
    a = 4'd9; b = 4'd4; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    e.r = 4'b1101; e.c = 1'b0; e.o = 1'b0; e.at = k + N;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    a = 4'd0; b = 4'd0; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset in the third SHIFT cycle aborts the operation
    @(negedge clk);
    a = 4'd1; b = 4'd1; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_cout", int'(cout), 0);
    chk("abort_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_busy", int'(busy), 0);
    do_op(4'd6, 4'd7, 1'b0, 4'b1101, 1'b0, 1'b1);

    // start held high: 3+1 then 6-6, done pulses 5 cycles apart
    @(negedge clk);
    a = 4'd3; b = 4'd1; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    e.r = 4'd4; e.c = 1'b0; e.o = 1'b0; e.at = k + N;
    sbq.push_back(e);
    @(negedge clk);
    a = 4'd6; b = 4'd6; mode = 1'b1;
    repeat (N + 1) @(posedge clk);
    #1;
    e.r = 4'd0; e.c = 1'b1; e.o = 1'b0; e.at = k + N + 1 + N;
    sbq.push_back(e);
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_serial_ctrl.md
# addsub_serial_ctrl

Sequencing controller for the 4-bit adder-subtractor datapath. It computes A ± B bit-serially, LSB first, through a single full-adder cell built from two half-adder stages, using one bit per clock. A start/busy/done handshake sequences the operation. The block sits between the lab's switch/register front end and the result display, and replaces the ripple adder-subtractor where area matters more than latency.

## Interface
Parameters:
- `N`, default 4: operand width in bits; legal values are N ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request to begin an operation; sampled only in IDLE or DONE.
- `mode`  in  1  0 = add (A+B), 1 = subtract (A−B, two's complement); sampled with `start`.
- `a`  in  N  operand A; sampled with `start`.
- `b`  in  N  operand B; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle onward.
- `result`  out  N  registered sum/difference.
- `cout`  out  1  final carry out. For subtract, 1 = no borrow.
- `ovf`  out  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + `start`=1:
  - latch `a` into the A shift register;
  - latch `b ^ {N{mode}}` into the B shift register;
  - set the carry register to `mode`;
  - clear the bit counter;
  - go to SHIFT.
- IDLE/DONE + `start`=0: DONE → IDLE; IDLE stays in IDLE.
- SHIFT, each cycle:
  - sum bit = A[0] ^ B[0] ^ carry; next carry = majority(A[0], B[0], carry);
  - shift the sum bit into the MSB of the internal accumulator;
  - shift A and B right by one;
  - increment the counter.
- SHIFT, after the N-th bit:
  - load the accumulator into `result` and the final carry into `cout`;
  - update `ovf`;
  - go to DONE.
- `start` in SHIFT is ignored. It is not queued.
- `result`, `cout` and `ovf` change only on the SHIFT→DONE transition or on reset. They hold their values through DONE, IDLE and the next operation until that operation completes.
- Arithmetic is modulo 2^N. The carry out of the MSB goes to `cout` only.
- `busy` = (state == SHIFT). `done` = (state == DONE).

## Timing
- Reset (`rst_n`=0 at a rising edge): state = IDLE, counter = 0, shift and carry registers = 0, `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0.
- Reset is honoured in any state. Reset mid-SHIFT aborts the operation and no `done` is produced.
- Let `start` be sampled at edge k:
  - `busy` is high for exactly N cycles, from after edge k to edge k+N;
  - `done` is high for the single cycle after edge k+N;
  - latency is N cycles from the start cycle to `done`.
- Back-to-back: `start` high during DONE is accepted.
  - `busy` rises in the next cycle, with no idle gap.
  - Throughput is one result per N+1 cycles.
- `start` held high continuously restarts the block on every DONE cycle.
- Operand or `mode` changes after the sampling edge have no effect on the operation in flight.

## Configuration
- `ADDSUB_OVF_EN` defined:
  - `ovf` = (carry into the MSB) ^ (carry out of the MSB) of the final bit step;
  - registered with `result`.
- `ADDSUB_OVF_EN` undefined:
  - the overflow logic is not built;
  - `ovf` is tied to 0;
  - the port list is unchanged.

## Test plan
All scenarios use N=4, with `ADDSUB_OVF_EN` defined unless noted.
- Add: a=5, b=3, mode=0 → after 4 busy cycles `done` pulses; result=4'b1000, cout=0, ovf=1.
- Subtract: a=7, b=2, mode=1 → result=4'b0101, cout=1, ovf=0. Then a=2, b=7, mode=1 → result=4'b1011, cout=0, ovf=0.
- Wrap: a=15, b=1, mode=0 → result=0, cout=1, ovf=0. Rebuild without `ADDSUB_OVF_EN` and repeat 5+3 → ovf stays 0.
- `start` pulsed, and operands changed to a=0, b=0, in the second SHIFT cycle → ignored. The original result is produced, and `done` arrives exactly 4 cycles after the first start.
- `rst_n`=0 in the third SHIFT cycle → next cycle state is IDLE with all outputs 0. No `done` follows, and a new start then completes normally.
- `start` held high across two operations (3+1, then 6−6) → `done` pulses are 5 cycles apart; results are 4 then 0, with cout 0 then 1.
